// File: rtl/load_store_unit.sv
// Data-memory initiator: checks a load/store request, drives memory for one cycle, returns a held response.
// Latency: legal request visible on resp two edges after acceptance; errored request visible one edge after.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module load_store_unit #(
    parameter int A_WIDTH     = 20,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_src,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_bad_funct3;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_err;
    logic [32:0] w_size;
    logic [32:0] w_last_byte;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Request legality: funct3 encoding, natural alignment, and last touched byte within the address window
    always_comb begin
        w_bad_funct3 = 1'b0;
        if (req_we) begin
            w_bad_funct3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            w_bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end

        w_misaligned = 1'b0;
        if (ALIGN_CHECK) begin
            w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        end

        case (req_funct3[1:0])
            2'b00:   w_size = 33'd1;
            2'b01:   w_size = 33'd2;
            default: w_size = 33'd4;
        endcase
        // 33-bit sum so an address near 2**32 cannot wrap back into range
        w_last_byte    = {1'b0, req_addr} + w_size - 33'd1;
        w_out_of_range = (w_last_byte >> A_WIDTH) != 33'd0;

        w_err = w_bad_funct3 || w_misaligned || w_out_of_range;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; write enable is gated by reset so an aborted access never commits
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_we       = r_we & ~rst;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch and response data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
                r_rdata  <= 32'd0;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= r_we ? 32'd0 : mem_rd;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_a      = r_addr;
    assign mem_wd     = r_wdata;
    assign mem_src    = r_funct3;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte memory model, an aligned-check instance and a pass-through instance.
// Expected responses are queued at issue time and compared by independent monitors on the falling edge.
// Response back-pressure is exercised by driving resp_ready low for several cycles.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
    logic [2:0]  mem_src;

    logic        d2_req_ready, d2_resp_valid, d2_resp_err, d2_mem_we;
    logic [31:0] d2_resp_rdata, d2_mem_a, d2_mem_wd;
    logic [2:0]  d2_mem_src;

    load_store_unit #(.A_WIDTH(20), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_src(mem_src), .mem_rd(mem_rd)
    );

    load_store_unit #(.A_WIDTH(20), .ALIGN_CHECK(1'b0)) dut_noalign (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d2_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d2_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(d2_resp_rdata), .resp_err(d2_resp_err),
        .mem_a(d2_mem_a), .mem_wd(d2_mem_wd), .mem_we(d2_mem_we), .mem_src(d2_mem_src), .mem_rd(32'd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte memory model, little endian, 4 KiB window aliased over the address space
    logic [7:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[11:0]] <= mem_wd[7:0];
            if (mem_src[1:0] != 2'b00) mem[mem_a[11:0] + 12'd1] <= mem_wd[15:8];
            if (mem_src[1:0] == 2'b10) begin
                mem[mem_a[11:0] + 12'd2] <= mem_wd[23:16];
                mem[mem_a[11:0] + 12'd3] <= mem_wd[31:24];
            end
        end
    end

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[mem_a[11:0]];
        b1 = mem[mem_a[11:0] + 12'd1];
        b2 = mem[mem_a[11:0] + 12'd2];
        b3 = mem[mem_a[11:0] + 12'd3];
        mem_rd = 32'd0;
        case (mem_src)
            3'b000:  mem_rd = {{24{b0[7]}}, b0};
            3'b100:  mem_rd = {24'd0, b0};
            3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
            3'b101:  mem_rd = {16'd0, b1, b0};
            default: mem_rd = {b3, b2, b1, b0};
        endcase
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } exp2_t;

    exp_t  q1[$];
    exp2_t q2[$];

    // Monitor for the aligned-check instance
    exp_t        e1;
    logic        seen1 = 1'b0;
    logic        prev_acc1 = 1'b0;
    logic [31:0] snap_rdata;
    logic        snap_err;
    int          we_cnt1 = 0;

    always @(negedge clk) begin
        if (rst) begin
            seen1     = 1'b0;
            prev_acc1 = 1'b0;
            we_cnt1   = 0;
        end else begin
            if (mem_we) we_cnt1++;
            if (prev_acc1) check("req_ready_after_accept", {31'd0, req_ready}, 32'd1);
            if (resp_valid) begin
                if (!seen1) begin
                    if (q1.size() == 0) begin
                        check("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e1 = q1.pop_front();
                        check("resp_rdata", resp_rdata, e1.rdata);
                        check("resp_err", {31'd0, resp_err}, {31'd0, e1.err});
                        check("resp_latency_cycle", cyc, e1.cyc);
                        check("mem_we_pulses", we_cnt1, e1.wr ? 32'd1 : 32'd0);
                    end
                    we_cnt1    = 0;
                    seen1      = 1'b1;
                    snap_rdata = resp_rdata;
                    snap_err   = resp_err;
                end else begin
                    check("held_rdata", resp_rdata, snap_rdata);
                    check("held_err", {31'd0, resp_err}, {31'd0, snap_err});
                end
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            prev_acc1 = resp_valid && resp_ready;
            if (resp_valid && resp_ready) seen1 = 1'b0;
        end
    end

    // Monitor for the pass-through instance: error flag, write pulses and memory-side fields
    exp2_t e2;
    logic  seen2 = 1'b0;
    int    we_cnt2 = 0;

    always @(negedge clk) begin
        if (rst) begin
            seen2   = 1'b0;
            we_cnt2 = 0;
        end else begin
            if (d2_mem_we) begin
                we_cnt2++;
                if (q2.size() != 0) begin
                    check("na_mem_a", d2_mem_a, q2[0].addr);
                    check("na_mem_wd", d2_mem_wd, q2[0].wdata);
                    check("na_mem_src", {29'd0, d2_mem_src}, {29'd0, q2[0].f3});
                end
            end
            if (d2_resp_valid && !seen2) begin
                if (q2.size() == 0) begin
                    check("na_unexpected_response", 32'd1, 32'd0);
                end else begin
                    e2 = q2.pop_front();
                    check("na_resp_err", {31'd0, d2_resp_err}, {31'd0, e2.err});
                    check("na_resp_rdata", d2_resp_rdata, 32'd0);
                    check("na_mem_we_pulses", we_cnt2, e2.wr ? 32'd1 : 32'd0);
                end
                we_cnt2 = 0;
                seen2   = 1'b1;
            end
            if (d2_resp_valid && resp_ready) seen2 = 1'b0;
        end
    end

    // Issue one request to both instances in the same cycle and queue the expected outcomes
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                         input logic exp_err2, input bit push);
        int   n;
        int   acc;
        exp_t  x;
        exp2_t y;
        n = 0;
        @(negedge clk);
        while (!(req_ready && d2_req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_req_ready_timeout", 32'd1, 32'd0);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        if (push) begin
            x.rdata = exp_rdata;
            x.err   = exp_err;
            x.wr    = we && !exp_err;
            x.cyc   = exp_err ? acc : acc + 1;
            q1.push_back(x);
            y.err   = exp_err2;
            y.wr    = we && !exp_err2;
            y.addr  = addr;
            y.wdata = wdata;
            y.f3    = f3;
            q2.push_back(y);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_ready && d2_req_ready && q1.size() == 0 && q2.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_mem_src", {29'd0, mem_src}, 32'd0);

        //     we    f3      addr           wdata          err   rdata          err2  push
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h0000_0104, 32'h1122_3344, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h0000_0200, 32'h0000_80F0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b0, 3'b000, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b1);
        issue(1'b0, 3'b100, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'h0000_00F0, 1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'hFFFF_80F0, 1'b0, 1'b1);
        issue(1'b0, 3'b101, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'h0000_80F0, 1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h0000_0101, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h0000_0102, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        wait_idle();
        check("mem_100", {24'd0, mem[12'h100]}, 32'h0000_00EF);
        check("mem_101", {24'd0, mem[12'h101]}, 32'h0000_00BE);
        check("mem_102", {24'd0, mem[12'h102]}, 32'h0000_00AD);
        check("mem_103", {24'd0, mem[12'h103]}, 32'h0000_00DE);
        check("mem_104", {24'd0, mem[12'h104]}, 32'h0000_0044);
        check("mem_107", {24'd0, mem[12'h107]}, 32'h0000_0011);

        issue(1'b0, 3'b010, 32'h000F_FFFD, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        issue(1'b0, 3'b000, 32'h000F_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        issue(1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        issue(1'b0, 3'b110, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        wait_idle();

        // Hold the response for five cycles before accepting it
        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("bp_wait_resp_timeout", 32'd1, 32'd0);
        repeat (5) @(negedge clk);
        resp_ready = 1'b1;
        wait_idle();

        // Reset lands in the ACCESS cycle of a store: no write, response dropped
        issue(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        wait_idle();
        issue(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_access_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_access_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_access_req_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);
        wait_idle();
        check("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. It accepts one load or store request at a time from the execute stage using a valid/ready handshake, and checks the request for funct3 legality, alignment and address range. A legal request drives the byte-addressed data memory for exactly one cycle. The unit then returns a registered, held response (load data or error) to the writeback stage.

## Interface
- A_WIDTH, 20, memory address width; addresses at or above 2**A_WIDTH are out of range
- ALIGN_CHECK, 1, 1 = halfword/word accesses must be naturally aligned; 0 = misaligned accesses are passed through to memory
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (loads 000/001/010/100/101; stores 000/001/010)
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bytes used for SB/SH)
- resp_valid  output  1  response held until accepted
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  sign/zero-extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3, misaligned or out-of-range request
- mem_a  output  32  memory byte address
- mem_wd  output  32  memory write data
- mem_we  output  1  memory write enable
- mem_src  output  3  memory size/sign code; equals funct3
- mem_rd  input  32  combinational memory read data, already sized and extended per mem_src

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, funct3, addr, wdata, and the error flag.
  - Next state is ACCESS if the request is legal; otherwise RESP with resp_err=1.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value with bit 2 set, or 011.
- Misaligned (only when ALIGN_CHECK=1):
  - funct3[1:0]=01 with addr[0]=1.
  - funct3[1:0]=10 with addr[1:0]≠00.
- Out of range: addr+size-1 ≥ 2**A_WIDTH, computed in 33 bits; size is 1, 2 or 4.
- ACCESS, exactly one cycle:
  - mem_a, mem_wd and mem_src come from the latched registers.
  - mem_we = latched_we & ~rst.
  - Load: resp_rdata <= mem_rd at the end of the cycle.
  - Store: resp_rdata <= 0.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - On resp_ready → IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- mem_we is 0 in every state except ACCESS. An errored request never reaches ACCESS, so memory is never written by it.
- mem_a, mem_wd and mem_src are held from the latched registers in all states.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready = 1 (the cycle after reset).
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_we = 0.
  - mem_a, mem_wd and mem_src = 0 (latched registers cleared).
- Legal request accepted at edge T:
  - ACCESS during cycle T..T+1.
  - resp_valid high from edge T+1.
  - Write commits at edge T+1.
  - Latency: 2 cycles from request cycle to response visible.
- Errored request accepted at edge T: resp_valid high from edge T; memory is untouched.
- Maximum throughput: one request per 3 cycles with resp_ready tied high.
- Back-pressure: resp_valid, resp_rdata and resp_err stay constant while resp_ready=0.
- Reset asserted during ACCESS:
  - mem_we is forced to 0, so no write occurs at that edge.
  - The FSM returns to IDLE and the response is dropped.
- Reset asserted during RESP: the response is dropped and resp_valid=0 after the edge.
- req_valid high outside IDLE is ignored; the request must be held by the source until req_ready.

## Test plan
- Store then load:
  - SW addr 0x100, wdata 0xDEADBEEF → mem_we high exactly one cycle, resp_err=0.
  - LW 0x100 → resp_rdata=0xDEADBEEF, 2 cycles after acceptance.
- Sign handling:
  - After SW 0x200=0x000080F0: LB 0x200 → 0xFFFFFFF0; LBU → 0x000000F0; LH → 0xFFFF80F0; LHU → 0x000080F0.
- Misalignment (ALIGN_CHECK=1):
  - LH 0x101 → resp_err=1, resp_rdata=0, mem_we never high.
  - SW 0x102 → resp_err=1, memory at 0x100..0x107 unchanged.
  - With ALIGN_CHECK=0, SW 0x102 succeeds.
- Range and funct3:
  - LW 0x000FFFFD (A_WIDTH=20) → resp_err=1; LB 0x000FFFFF → resp_err=0.
  - Load funct3 011 → resp_err=1; store funct3 100 → resp_err=1.
- Back-pressure: hold resp_ready=0 for 5 cycles after LW → resp_valid and data stable, req_ready=0 throughout; accepted on the first resp_ready=1 cycle, req_ready=1 the next cycle.
- Reset during ACCESS: SW 0x300=0x12345678 with rst asserted in the ACCESS cycle → no write (later LW 0x300 returns the prior value), resp_valid=0, req_ready=1 after reset.
